// File: rtl/prio_encode_rr_pkg.sv
// prio_encode_pkg: shared constants and helpers for the prio_encode_rr block.
//   PRIO_FIXED / PRIO_RR : values for the RR_MODE parameter.
//   clog2_min1()         : index width helper, never returns less than 1.
package prio_encode_pkg;

  localparam int PRIO_FIXED = 0;
  localparam int PRIO_RR    = 1;

  // A 2-entry (or smaller) vector still needs a 1-bit index.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/prio_encode_rr_if.sv
// prio_encode_rr_if: request/result handshake bundle for prio_encode_rr.
//   in_valid/in_ready/in_req                     : request channel (into encoder)
//   out_valid/out_ready/out_idx/out_onehot/out_hit : result channel (out of encoder)
//   out_multi                                     : only when PRIO_ENCODE_MULTIHOT_EN is defined
// Modports: master = request producer / result consumer, slave = the encoder.
interface prio_encode_rr_if #(
  parameter  int WIDTH = 8,
  localparam int IDX_W = prio_encode_pkg::clog2_min1(WIDTH)
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_req;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic [WIDTH-1:0] out_onehot;
  logic             out_hit;
`ifdef PRIO_ENCODE_MULTIHOT_EN
  logic             out_multi;
`endif

  modport master (
    output in_valid, in_req, out_ready,
    input  in_ready, out_valid, out_idx, out_onehot, out_hit
`ifdef PRIO_ENCODE_MULTIHOT_EN
    , input out_multi
`endif
  );

  modport slave (
    input  in_valid, in_req, out_ready,
    output in_ready, out_valid, out_idx, out_onehot, out_hit
`ifdef PRIO_ENCODE_MULTIHOT_EN
    , output out_multi
`endif
  );
endinterface

// File: rtl/prio_encode_rr_find.sv
// prio_find_first: combinational first-set-bit search with wrap-around.
//   req   : request bits
//   start : position where the search begins (must be < WIDTH)
//   idx   : first set position found at or after start, wrapping past WIDTH-1
//   hit   : at least one bit of req is set (idx is 0 when clear)
module prio_find_first #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic [WIDTH-1:0] req,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             hit
);

  // Returns {hit, idx}. Positions are computed with an explicit subtract
  // so non-power-of-two widths wrap at WIDTH, not at 2**IDX_W.
  function automatic logic [IDX_W:0] search(input logic [WIDTH-1:0] r,
                                            input logic [IDX_W-1:0] s);
    logic             found;
    logic [IDX_W-1:0] res;
    int               pos;
    found = 1'b0;
    res   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pos = int'(s) + i;
      if (pos >= WIDTH) pos = pos - WIDTH;
      if (!found && r[pos[IDX_W-1:0]]) begin
        found = 1'b1;
        res   = IDX_W'(pos);
      end
    end
    return {found, res};
  endfunction

  assign {hit, idx} = search(req, start);

endmodule

// File: rtl/prio_encode_rr.sv
// prio_encode_rr: registered priority encoder with fixed or round-robin search.
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : prio_encode_rr_if.slave (request in, result out, latency 1)
// Parameters: WIDTH (>=2), RR_MODE (PRIO_FIXED / PRIO_RR); IDX_W is derived.
// Optional: PRIO_ENCODE_MULTIHOT_EN adds out_multi (more than one bit set).
module prio_encode_rr
  import prio_encode_pkg::*;
#(
  parameter  int WIDTH   = 8,
  parameter  int RR_MODE = PRIO_FIXED,
  localparam int IDX_W   = clog2_min1(WIDTH)
) (
  input logic            clk,
  input logic            rst_n,
  prio_encode_rr_if.slave bus
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] start;
  logic [IDX_W-1:0] f_idx;
  logic             f_hit;
  logic             accept;

  // Only depends on registered state and out_ready, never on in_valid/in_req.
  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // Fixed mode always searches from bit 0; ptr then stays at its reset value.
  assign start = (RR_MODE == PRIO_RR) ? ptr : '0;

  prio_find_first #(
    .WIDTH (WIDTH),
    .IDX_W (IDX_W)
  ) u_find (
    .req   (bus.in_req),
    .start (start),
    .idx   (f_idx),
    .hit   (f_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid  <= 1'b0;
      bus.out_idx    <= '0;
      bus.out_onehot <= '0;
      bus.out_hit    <= 1'b0;
`ifdef PRIO_ENCODE_MULTIHOT_EN
      bus.out_multi  <= 1'b0;
`endif
      ptr            <= '0;
    end else if (accept) begin
      bus.out_valid  <= 1'b1;
      bus.out_idx    <= f_hit ? f_idx : '0;
      bus.out_onehot <= f_hit ? (WIDTH'(1) << f_idx) : '0;
      bus.out_hit    <= f_hit;
`ifdef PRIO_ENCODE_MULTIHOT_EN
      // Clearing the lowest set bit leaves something only if two or more were set.
      bus.out_multi  <= |(bus.in_req & (bus.in_req - WIDTH'(1)));
`endif
      // Explicit wrap keeps ptr inside 0..WIDTH-1 for non-power-of-two widths.
      if (RR_MODE == PRIO_RR && f_hit) begin
        ptr <= (f_idx == IDX_W'(WIDTH - 1)) ? '0 : IDX_W'(f_idx + 1'b1);
      end
    end else if (bus.out_ready) begin
      // Drain with nothing new: data registers keep their last value.
      bus.out_valid <= 1'b0;
    end
  end

endmodule
